// File: rtl/barshift_rr_sched.sv
// barshift_rr_sched: round-robin shared, DEPTH-stage pipelined rotate-right barrel shifter.
// Define BARSHIFT_RR_SCHED_PRIO_EN to give requester 0 strict priority over the round-robin.
module barshift_rr_sched #(
    parameter int NREQ = 4,
    parameter int DEPTH = 3,
    localparam int WIDTH = 2 ** DEPTH,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         in_valid,
    output logic [NREQ-1:0]         in_ready,
    input  logic [NREQ*WIDTH-1:0]   in_data,
    input  logic [NREQ*DEPTH-1:0]   in_shift,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [IDW-1:0]          out_id,
    output logic                    busy
);
    logic [DEPTH-1:0] sv;
    logic [WIDTH-1:0] sd [DEPTH];
    logic [DEPTH-1:0] ss [DEPTH];
    logic [IDW-1:0]   sid [DEPTH];
    logic [IDW-1:0]   ptr, grant;
    logic             found, advance, push;
    logic [WIDTH-1:0] din;
    logic [DEPTH-1:0] sin;

    function automatic logic [WIDTH-1:0] rot(input logic [WIDTH-1:0] d, input int k);
        return (d >> (1 << k)) | (d << (WIDTH - (1 << k)));
    endfunction

    // Wraps a search index back into the range [lo, NREQ-1].
    function automatic logic [IDW-1:0] wrap(input int v, input int lo);
        return IDW'(v >= NREQ ? v - NREQ + lo : v);
    endfunction

    assign advance = !(out_valid && !out_ready);
    assign push = found && advance && !rst;

    always_comb begin
        grant = '0;
        found = 1'b0;
`ifdef BARSHIFT_RR_SCHED_PRIO_EN
        if (in_valid[0]) begin
            found = 1'b1;
        end else begin
            for (int i = 0; i < NREQ - 1; i++) begin
                if (!found && in_valid[wrap((ptr == '0 ? 1 : int'(ptr)) + i, 1)]) begin
                    found = 1'b1;
                    grant = wrap((ptr == '0 ? 1 : int'(ptr)) + i, 1);
                end
            end
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            if (!found && in_valid[wrap(int'(ptr) + i, 0)]) begin
                found = 1'b1;
                grant = wrap(int'(ptr) + i, 0);
            end
        end
`endif
    end

    always_comb begin
        din = '0;
        sin = '0;
        in_ready = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (grant == IDW'(r)) begin
                din = in_data[r*WIDTH +: WIDTH];
                sin = in_shift[r*DEPTH +: DEPTH];
                in_ready[r] = push;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sv <= '0;
            ptr <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                sd[k] <= '0;
                ss[k] <= '0;
                sid[k] <= '0;
            end
        end else begin
            if (advance) begin
                sv <= {sv[DEPTH-2:0], push};
                sd[0] <= sin[0] ? rot(din, 0) : din;
                ss[0] <= sin;
                sid[0] <= grant;
                for (int k = 1; k < DEPTH; k++) begin
                    sd[k] <= ss[k-1][k] ? rot(sd[k-1], k) : sd[k-1];
                    ss[k] <= ss[k-1];
                    sid[k] <= sid[k-1];
                end
            end
`ifdef BARSHIFT_RR_SCHED_PRIO_EN
            if (push && grant != '0)
`else
            if (push)
`endif
                ptr <= grant == IDW'(NREQ - 1) ? '0 : grant + 1'b1;
        end
    end

    assign out_valid = sv[DEPTH-1];
    assign out_data = sd[DEPTH-1];
    assign out_id = sid[DEPTH-1];
    assign busy = |sv;
endmodule

// File: tb/tb_barshift_rr_sched.sv
// tb_barshift_rr_sched: directed tests for the shared rotate-right shifter, NREQ=4 and NREQ=3.
module tb_barshift_rr_sched;
`ifdef BARSHIFT_RR_SCHED_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] in_valid = '0, in_ready;
    logic [31:0] in_data = '0;
    logic [11:0] in_shift = '0;
    logic out_valid, out_ready = 1'b1, busy;
    logic [7:0] out_data;
    logic [1:0] out_id;
    logic [2:0] v3 = '0, rdy3;
    logic [23:0] d3 = '0;
    logic [8:0] sh3 = '0;
    logic ov3, busy3;
    logic [7:0] od3;
    logic [1:0] oid3;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    barshift_rr_sched #(.NREQ(4), .DEPTH(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shift(in_shift), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_id(out_id), .busy(busy)
    );

    barshift_rr_sched #(.NREQ(3), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .in_data(d3),
        .in_shift(sh3), .out_valid(ov3), .out_ready(1'b1), .out_data(od3),
        .out_id(oid3), .busy(busy3)
    );

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        v3 = '0;
        out_ready = 1'b1;
        in_data = '0;
        in_shift = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 4'hF;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 4'b0 || out_data !== 8'h00 || out_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_values: got v=%b busy=%b rdy=%b d=%h id=%0d, want all 0",
                     out_valid, busy, in_ready, out_data, out_id);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp [8] = '{8'h8E, 8'h47, 8'hA3, 8'hD1, 8'hE8, 8'h74, 8'h3A, 8'h1D};
        do_reset();
        in_data[7:0] = 8'h8E;
        for (int i = 0; i < 11; i++) begin
            if (i >= 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp[i-3] || out_id !== 2'd0) begin
                    errors++;
                    $display("FAIL single_out[%0d]: got v=%b d=%h id=%0d, want v=1 d=%h id=0",
                             i - 3, out_valid, out_data, out_id, exp[i-3]);
                end
            end
            in_valid = i < 8 ? 4'b0001 : 4'b0000;
            in_shift[2:0] = 3'(i);
            #1;
            if (i < 8) begin
                checks++;
                if (in_ready !== 4'b0001) begin
                    errors++;
                    $display("FAIL single_ready[%0d]: got %b, want 0001", i, in_ready);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got busy=%b v=%b, want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_rr();
        int cnt [4] = '{0, 0, 0, 0};
        do_reset();
        in_valid = 4'hF;
        in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 15; i++) begin
            if (i >= 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_id !== 2'((i - 3) % 4) || out_data !== 8'(8'h11 * ((i - 3) % 4 + 1))) begin
                    errors++;
                    $display("FAIL rr_out[%0d]: got v=%b id=%0d d=%h, want v=1 id=%0d d=%h", i, out_valid,
                             out_id, out_data, (i - 3) % 4, 8'(8'h11 * ((i - 3) % 4 + 1)));
                end
            end
            #1;
            checks++;
            if (in_ready !== 4'(1 << (i % 4))) begin
                errors++;
                $display("FAIL rr_ready[%0d]: got %b, want %b", i, in_ready, 4'(1 << (i % 4)));
            end
            for (int k = 0; k < 4; k++) if (i < 12 && in_ready[k]) cnt[k]++;
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cnt[k] != 3) begin
                errors++;
                $display("FAIL rr_share[%0d]: got %0d grants, want 3", k, cnt[k]);
            end
        end
    endtask

    task automatic test_prio();
        logic [3:0] exp [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid = i < 4 ? 4'hF : 4'hE;
            #1;
            checks++;
            if (in_ready !== exp[i]) begin
                errors++;
                $display("FAIL prio_ready[%0d]: got %b, want %b", i, in_ready, exp[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] dat [8] = '{8'h8E, 8'h01, 8'h80, 8'hFF, 8'h3C, 8'h55, 8'h0F, 8'hF0};
        logic [7:0] exp [8] = '{8'hD1, 8'h20, 8'h10, 8'hFF, 8'h87, 8'hAA, 8'hE1, 8'h1E};
        int p = 0;
        int q = 0;
        do_reset();
        in_shift[2:0] = 3'd3;
        for (int c = 0; c < 22; c++) begin
            out_ready = !(c >= 3 && c < 8);
            if (out_valid) begin
                checks++;
                if (q >= 8) begin
                    errors++;
                    $display("FAIL bp_extra[%0d]: got d=%h, want no output", c, out_data);
                end else if (out_data !== exp[q] || out_id !== 2'd0) begin
                    errors++;
                    $display("FAIL bp_data[%0d]: got d=%h id=%0d, want d=%h id=0", c, out_data, out_id, exp[q]);
                end
                if (out_ready) q++;
            end
            in_valid = p < 8 ? 4'b0001 : 4'b0000;
            in_data[7:0] = p < 8 ? dat[p] : 8'h00;
            #1;
            if (!out_ready) begin
                checks++;
                if (in_ready !== 4'b0000 || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_stall[%0d]: got rdy=%b v=%b, want rdy=0000 v=1", c, in_ready, out_valid);
                end
            end
            if (in_ready[0]) p++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (p != 8 || q != 8 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_count: got sent=%0d recv=%0d busy=%b, want 8 8 0", p, q, busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 4'b0001;
        in_data = {8'h00, 8'h00, 8'h5A, 8'h8E};
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_full: got busy=%b v=%b, want 1 1", busy, out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mid_flush: got v=%b busy=%b rdy=%b, want 0 0 0000", out_valid, busy, in_ready);
        end
        in_valid = 4'b0110;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL mid_first_grant: got %b, want 0010", in_ready);
        end
        for (int i = 1; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) in_valid = 4'b0000;
            checks++;
            if (out_valid !== (i == 3) || (i == 3 && (out_id !== 2'd1 || out_data !== 8'h5A))) begin
                errors++;
                $display("FAIL mid_after[%0d]: got v=%b id=%0d d=%h, want v=%0d id=1 d=5a",
                         i, out_valid, out_id, out_data, i == 3);
            end
        end
    endtask

    task automatic test_nonpow2();
        do_reset();
        v3 = 3'b101;
        d3 = {8'hC3, 8'h00, 8'h3C};
        for (int i = 0; i < 9; i++) begin
            if (i >= 3) begin
                checks++;
                if (ov3 !== 1'b1 || oid3 !== ((PRIO || (i - 3) % 2 == 0) ? 2'd0 : 2'd2)
                    || od3 !== ((PRIO || (i - 3) % 2 == 0) ? 8'h3C : 8'hC3)) begin
                    errors++;
                    $display("FAIL np2_out[%0d]: got v=%b id=%0d d=%h", i, ov3, oid3, od3);
                end
            end
            #1;
            checks++;
            if (rdy3 !== ((PRIO || i % 2 == 0) ? 3'b001 : 3'b100)) begin
                errors++;
                $display("FAIL np2_ready[%0d]: got %b, want %b", i, rdy3, (PRIO || i % 2 == 0) ? 3'b001 : 3'b100);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_single();
`ifdef BARSHIFT_RR_SCHED_PRIO_EN
        test_prio();
`else
        test_rr();
`endif
        test_backpressure();
        test_reset_mid();
        test_nonpow2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
